cache_lookup_ctrl: RTL and testbench

CACHE_LOOKUP_CTRL -- requirements
Module: cache_lookup_ctrl

---
 rtl/cache_lookup_ctrl_if.sv | 62 ++++++
 rtl/cache_lookup_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_cache_lookup_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_lookup_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_lookup_ctrl_if
// Bundles every non-clock/reset signal of the 2-way cache lookup controller.
//   slave  : controller view (drives req_ready_o, resp_*_o, lookup status,
//            refill request and fill strobes)
//   master : environment view (CPU request/response side, replacement policy,
//            refill memory port)
// Parameters must match the controller instance: ADDR_W (address width) and
// SETS (number of sets, power of two).
// -----------------------------------------------------------------------------
interface cache_lookup_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int SETS   = 128
);
    localparam int IDX_W = $clog2(SETS);

    // CPU request / response
    logic              req_valid_i;
    logic              req_ready_o;
    logic [ADDR_W-1:0] req_addr_i;
    logic              flush_i;
    logic              resp_valid_o;
    logic              resp_ready_i;
    logic              resp_hit_o;
    logic              resp_way_o;

    // Lookup status towards the replacement policy
    logic [IDX_W-1:0]  set_index_o;
    logic              way0_valid_o;
    logic              way1_valid_o;
    logic              hit_o;
    logic              miss_o;
    logic              way_hit_o;
    logic              way_to_evict_i;

    // Refill memory port and data-array fill strobes
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_resp_valid_i;
    logic              fill_we_o;
    logic              fill_way_o;
    logic [IDX_W-1:0]  fill_set_o;

    modport slave (
        input  req_valid_i, req_addr_i, flush_i, resp_ready_i,
               way_to_evict_i, mem_req_ready_i, mem_resp_valid_i,
        output req_ready_o, resp_valid_o, resp_hit_o, resp_way_o,
               set_index_o, way0_valid_o, way1_valid_o, hit_o, miss_o,
               way_hit_o, mem_req_valid_o, mem_addr_o, fill_we_o,
               fill_way_o, fill_set_o
    );

    modport master (
        output req_valid_i, req_addr_i, flush_i, resp_ready_i,
               way_to_evict_i, mem_req_ready_i, mem_resp_valid_i,
        input  req_ready_o, resp_valid_o, resp_hit_o, resp_way_o,
               set_index_o, way0_valid_o, way1_valid_o, hit_o, miss_o,
               way_hit_o, mem_req_valid_o, mem_addr_o, fill_we_o,
               fill_way_o, fill_set_o
    );
endinterface

// File: rtl/cache_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// cache_lookup_ctrl
// Tag/valid store and control FSM of a 2-way set-associative cache lookup.
// A request is latched in IDLE, compared against both ways for one cycle
// (LOOKUP), and either answered immediately (hit) or refilled from memory
// into the victim way chosen by an external replacement policy (miss).
// Ports:
//   clk_i  - clock, all state on rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - cache_lookup_ctrl_if.slave: CPU request/response, flush,
//            lookup status (set_index_o, wayN_valid_o, hit_o/miss_o,
//            way_hit_o, way_to_evict_i), refill handshake and fill strobes
// -----------------------------------------------------------------------------
module cache_lookup_ctrl #(
    parameter int SETS       = 128,
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    cache_lookup_ctrl_if.slave  bus
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        REFILL_REQ,
        REFILL_WAIT,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              victim_q;
    logic              resp_hit_q;
    logic              resp_way_q;
    logic [SETS-1:0]   valid0_q;
    logic [SETS-1:0]   valid1_q;
    logic [TAG_W-1:0]  tag0_q [SETS];
    logic [TAG_W-1:0]  tag1_q [SETS];

    logic [IDX_W-1:0]  set_idx;
    logic [TAG_W-1:0]  tag_c;
    logic              hit0;
    logic              hit1;
    logic              fill_en;
    logic              flush_en;

    // Offset bits never influence lookup or refill address.
    logic              unused_offset;
    assign unused_offset = ^bus.req_addr_i[OFF_W-1:0] ^ ^addr_q[OFF_W-1:0];

    assign set_idx  = addr_q[OFF_W +: IDX_W];
    assign tag_c    = addr_q[ADDR_W-1 -: TAG_W];
    assign hit0     = valid0_q[set_idx] && (tag0_q[set_idx] == tag_c);
    assign hit1     = valid1_q[set_idx] && (tag1_q[set_idx] == tag_c);
    // A fill only happens in REFILL_WAIT; stray refill beats elsewhere are dropped.
    assign fill_en  = (state_q == REFILL_WAIT) && bus.mem_resp_valid_i;
    assign flush_en = (state_q == IDLE) && bus.flush_i;

    // Status of the latched set is visible in every state.
    assign bus.set_index_o  = set_idx;
    assign bus.way0_valid_o = valid0_q[set_idx];
    assign bus.way1_valid_o = valid1_q[set_idx];

    // NOTE: every signal assigned here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d             = state_q;
        bus.req_ready_o     = 1'b0;
        bus.hit_o           = 1'b0;
        bus.miss_o          = 1'b0;
        bus.way_hit_o       = 1'b0;
        bus.mem_req_valid_o = 1'b0;
        bus.mem_addr_o      = '0;
        bus.fill_we_o       = 1'b0;
        bus.fill_way_o      = 1'b0;
        bus.fill_set_o      = '0;
        bus.resp_valid_o    = 1'b0;
        bus.resp_hit_o      = 1'b0;
        bus.resp_way_o      = 1'b0;

        case (state_q)
            IDLE: begin
                bus.req_ready_o = !bus.flush_i;
                if (bus.req_valid_i && !bus.flush_i) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit0 || hit1) begin
                    bus.hit_o     = 1'b1;
                    // Way 0 takes priority if both ways ever match.
                    bus.way_hit_o = !hit0;
                    state_d       = RESP;
                end else begin
                    bus.miss_o = 1'b1;
                    state_d    = REFILL_REQ;
                end
            end
            REFILL_REQ: begin
                bus.mem_req_valid_o = 1'b1;
                bus.mem_addr_o      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (bus.mem_req_ready_i) begin
                    state_d = REFILL_WAIT;
                end
            end
            REFILL_WAIT: begin
                if (fill_en) begin
                    bus.fill_we_o  = 1'b1;
                    bus.fill_way_o = victim_q;
                    bus.fill_set_o = set_idx;
                    state_d        = RESP;
                end
            end
            RESP: begin
                bus.resp_valid_o = 1'b1;
                bus.resp_hit_o   = resp_hit_q;
                bus.resp_way_o   = resp_way_q;
                if (bus.resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            victim_q   <= 1'b0;
            resp_hit_q <= 1'b0;
            resp_way_q <= 1'b0;
            valid0_q   <= '0;
            valid1_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (flush_en) begin
                        valid0_q <= '0;
                        valid1_q <= '0;
                    end else if (bus.req_valid_i) begin
                        addr_q <= bus.req_addr_i;
                    end
                end
                LOOKUP: begin
                    if (hit0 || hit1) begin
                        resp_hit_q <= 1'b1;
                        resp_way_q <= !hit0;
                    end else begin
                        victim_q <= bus.way_to_evict_i;
                    end
                end
                REFILL_WAIT: begin
                    // Valid bit is set only on the fill edge, so a reset
                    // earlier in the refill leaves nothing half-installed.
                    if (fill_en) begin
                        if (victim_q) begin
                            valid1_q[set_idx] <= 1'b1;
                        end else begin
                            valid0_q[set_idx] <= 1'b1;
                        end
                        resp_hit_q <= 1'b0;
                        resp_way_q <= victim_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag storage is a plain memory with no reset; valid bits gate
    // every use of a tag, so its power-up content never matters.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            if (victim_q) begin
                tag1_q[set_idx] <= tag_c;
            end else begin
                tag0_q[set_idx] <= tag_c;
            end
        end
    end
endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_lookup_ctrl
// Self-checking bench for cache_lookup_ctrl: a table of lookup transactions
// with expected hit/way/valid status, a response scoreboard, and hand-written
// sequences for flush and reset in the middle of a refill.
// -----------------------------------------------------------------------------
module tb_cache_lookup_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cache_lookup_ctrl_if #(.ADDR_W(32), .SETS(128)) bus ();

    cache_lookup_ctrl #(
        .SETS       (128),
        .ADDR_W     (32),
        .LINE_BYTES (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] addr;
        logic        evict;       // way_to_evict_i offered in LOOKUP
        int          mem_stall;   // cycles mem_req_ready_i stays low
        int          resp_stall;  // cycles resp_ready_i stays low
        logic        flush_wait;  // flush_i held high during REFILL_WAIT
        logic        hit;         // expected outcome
        logic        way;         // expected hit / filled way
        logic        v0;          // expected way0_valid_o during LOOKUP
        logic        v1;          // expected way1_valid_o during LOOKUP
    } vec_t;

    typedef struct {
        logic hit;
        logic way;
    } resp_t;

    resp_t sb_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    vec_t  vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE, ends at a negedge back in IDLE.
    task automatic run_txn(input vec_t v);
        resp_t       r;
        logic [31:0] line;
        logic [31:0] addr;
        logic [6:0]  set;
        addr = v.addr;
        line = addr & 32'hFFFF_FFF0;
        set  = addr[10:4];

        check("req_ready idle", bus.req_ready_o, 1);
        bus.req_valid_i    = 1'b1;
        bus.req_addr_i     = addr;
        bus.way_to_evict_i = v.evict;
        sb_q.push_back('{hit: v.hit, way: v.way});
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("hit_o", bus.hit_o, v.hit);
        check("miss_o", bus.miss_o, !v.hit);
        check("way_hit_o", bus.way_hit_o, v.hit ? v.way : 1'b0);
        check("set_index_o", bus.set_index_o, set);
        check("way0_valid_o", bus.way0_valid_o, v.v0);
        check("way1_valid_o", bus.way1_valid_o, v.v1);

        if (!v.hit) begin
            @(negedge clk);
            // Victim must already be latched; flipping the input now is harmless.
            bus.way_to_evict_i = !v.evict;
            for (int i = 0; i < v.mem_stall; i++) begin
                check("mem_req_valid stall", bus.mem_req_valid_o, 1);
                check("mem_addr stall", bus.mem_addr_o, line);
                check("miss_o one pulse", bus.miss_o, 0);
                @(negedge clk);
            end
            check("mem_req_valid", bus.mem_req_valid_o, 1);
            check("mem_addr", bus.mem_addr_o, line);
            bus.mem_req_ready_i = 1'b1;
            @(negedge clk);
            bus.mem_req_ready_i = 1'b0;
            check("mem_req_valid after accept", bus.mem_req_valid_o, 0);
            bus.flush_i = v.flush_wait;
            check("fill_we before data", bus.fill_we_o, 0);
            @(negedge clk);
            bus.mem_resp_valid_i = 1'b1;
            #1;
            check("fill_we", bus.fill_we_o, 1);
            check("fill_way", bus.fill_way_o, v.way);
            check("fill_set", bus.fill_set_o, set);
            @(negedge clk);
            bus.mem_resp_valid_i = 1'b0;
            bus.flush_i          = 1'b0;
        end else begin
            @(negedge clk);
        end

        for (int i = 0; i < v.resp_stall; i++) begin
            check("resp_valid held", bus.resp_valid_o, 1);
            check("resp_hit held", bus.resp_hit_o, v.hit);
            check("resp_way held", bus.resp_way_o, v.way);
            @(negedge clk);
        end
        check("resp_valid", bus.resp_valid_o, 1);
        check("no mem_req in resp", bus.mem_req_valid_o, 0);
        if (sb_q.size() == 0) begin
            check("scoreboard empty", 1, 0);
        end else begin
            r = sb_q.pop_front();
            check("resp_hit", bus.resp_hit_o, r.hit);
            check("resp_way", bus.resp_way_o, r.way);
        end
        bus.resp_ready_i = 1'b1;
        @(negedge clk);
        bus.resp_ready_i = 1'b0;
        check("resp_valid after accept", bus.resp_valid_o, 0);
    endtask

    // Drives a missing request up to the REFILL_REQ state (ends at a negedge).
    task automatic go_refill_req(input logic [31:0] addr, input logic evict);
        bus.req_valid_i    = 1'b1;
        bus.req_addr_i     = addr;
        bus.way_to_evict_i = evict;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        check("manual miss_o", bus.miss_o, 1);
        @(negedge clk);
        check("manual mem_req_valid", bus.mem_req_valid_o, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //           addr          ev   ms rs fw    hit   way   v0    v1
        vecs[0]  = '{32'h0000_1230, 1'b0, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_1234, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{32'h0000_1A30, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{32'h0000_1A3C, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4]  = '{32'h0000_2230, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{32'h0000_1230, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{32'h0000_1A30, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{32'h0000_0040, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'hFFFF_FFF0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32'hFFFF_FFFF, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{32'h0000_0044, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst                  = 1'b1;
        bus.req_valid_i      = 1'b0;
        bus.req_addr_i       = '0;
        bus.flush_i          = 1'b0;
        bus.resp_ready_i     = 1'b0;
        bus.way_to_evict_i   = 1'b0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst resp_valid", bus.resp_valid_o, 0);
        check("rst mem_req_valid", bus.mem_req_valid_o, 0);
        check("rst mem_addr", bus.mem_addr_o, 0);
        check("rst hit_o", bus.hit_o, 0);
        check("rst miss_o", bus.miss_o, 0);
        check("rst fill_we", bus.fill_we_o, 0);
        check("rst set_index", bus.set_index_o, 0);
        check("rst way0_valid", bus.way0_valid_o, 0);
        check("rst way1_valid", bus.way1_valid_o, 0);
        rst = 1'b0;
        @(negedge clk);
        check("req_ready after rst", bus.req_ready_o, 1);

        foreach (vecs[i]) run_txn(vecs[i]);

        // Flush in IDLE blocks the request and clears every valid bit.
        bus.flush_i     = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0000_1A30;
        #1;
        check("req_ready during flush", bus.req_ready_o, 0);
        @(negedge clk);
        bus.flush_i     = 1'b0;
        bus.req_valid_i = 1'b0;
        #1;
        check("flush no lookup hit", bus.hit_o, 0);
        check("flush no lookup miss", bus.miss_o, 0);
        check("flush way1_valid", bus.way1_valid_o, 0);
        check("req_ready after flush", bus.req_ready_o, 1);
        @(negedge clk);
        v = '{32'h0000_1A30, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        run_txn(v);
        v = '{32'h0000_1A30, 1'b0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        run_txn(v);

        // Reset in REFILL_REQ drops the memory request at once.
        go_refill_req(32'h0000_1230, 1'b0);
        rst = 1'b1;
        #1;
        check("rst drops mem_req_valid", bus.mem_req_valid_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset in REFILL_WAIT with a late refill beat: nothing installs.
        go_refill_req(32'h0000_1A30, 1'b0);
        bus.mem_req_ready_i = 1'b1;
        @(negedge clk);
        bus.mem_req_ready_i  = 1'b0;
        rst                  = 1'b1;
        bus.mem_resp_valid_i = 1'b1;
        #1;
        check("rst wait mem_req_valid", bus.mem_req_valid_o, 0);
        check("rst wait fill_we", bus.fill_we_o, 0);
        check("rst wait way0_valid", bus.way0_valid_o, 0);
        check("rst wait way1_valid", bus.way1_valid_o, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("late mem_resp ignored", bus.fill_we_o, 0);
        check("late mem_resp no resp", bus.resp_valid_o, 0);
        @(negedge clk);
        bus.mem_resp_valid_i = 1'b0;
        v = '{32'h0000_1230, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_txn(v);
        v = '{32'h0000_1A30, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        run_txn(v);
        v = '{32'h0000_1234, 1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        run_txn(v);

        check("scoreboard drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
